// File: rtl/fetch_unit.sv
// Instruction fetch stage: one word per cycle from the icache into a single
// output register toward decode, with stall, redirect/flush and halt support.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h00000000,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [0:0] ST_FETCH  = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic [31:0] r_count;

  logic        w_le;
  logic        w_is_halt;

  // Output register may refill whenever decode takes it or it is empty.
  assign w_le      = !stall || !r_valid;
  assign w_is_halt = (imemload[31:26] == HALT_OP);

  // Fetch request depends only on registered state, never on icache inputs.
  assign imemREN  = (r_state == ST_FETCH);
  assign imemaddr = {r_pc[31:2], 2'b00};

  assign valid_out   = r_valid;
  assign instr_out   = r_instr;
  assign pc_out      = r_pc_out;
  assign npc_out     = r_pc_out + 32'd4;
  assign halted      = (r_state == ST_HALTED);
  assign fetch_count = r_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_FETCH;
      r_pc     <= PC_INIT;
      r_valid  <= 1'b0;
      r_instr  <= 32'h0;
      r_pc_out <= 32'h0;
      r_count  <= 32'h0;
    end else if (redirect) begin
      // Flush wins over stall and halt; the in-flight icache word is dropped.
      r_state <= ST_FETCH;
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_valid <= 1'b0;
    end else if (w_le) begin
      if (r_state == ST_FETCH && ihit) begin
        r_instr  <= imemload;
        r_pc_out <= r_pc;
        r_valid  <= 1'b1;
        r_count  <= r_count + 32'd1;
        if (w_is_halt) r_state <= ST_HALTED;
        else           r_pc    <= r_pc + 32'd4;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
